// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load alignment and extension, bubble insertion,
// x0 write suppression and a retired-instruction counter.
module mem_wb_stage #(
    parameter int addWidth  = 5,
    parameter int dataWidth = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 STALL,
    input  logic                 FLUSH,
    input  logic                 ValidM,
    input  logic                 RegWriteM,
    input  logic                 MemtoRegM,
    input  logic [2:0]           LoadTypeM,
    input  logic [addWidth-1:0]  WriteRegM,
    input  logic [dataWidth-1:0] ALUOutM,
    input  logic [dataWidth-1:0] ReadDataM,
    output logic                 RegWriteW,
    output logic [addWidth-1:0]  WriteRegW,
    output logic [dataWidth-1:0] ResultW,
    output logic                 ValidW,
    output logic [31:0]          RetiredCount
);

    logic                 regwrite_q, regwrite_d;
    logic [addWidth-1:0]  writereg_q, writereg_d;
    logic [dataWidth-1:0] result_q, result_d;
    logic                 valid_q, valid_d;
    logic [31:0]          retired_cnt_q, retired_cnt_d;

    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [dataWidth-1:0] load_data;

    // Little-endian lane select; halfword ignores ALUOutM[0]
    always_comb begin
        byte_sel = ReadDataM[7:0];
        unique case (ALUOutM[1:0])
            2'd0: byte_sel = ReadDataM[7:0];
            2'd1: byte_sel = ReadDataM[15:8];
            2'd2: byte_sel = ReadDataM[23:16];
            2'd3: byte_sel = ReadDataM[31:24];
            default: byte_sel = ReadDataM[7:0];
        endcase
        half_sel = ALUOutM[1] ? ReadDataM[31:16] : ReadDataM[15:0];
    end

    always_comb begin
        load_data = ReadDataM;
        case (LoadTypeM)
            3'b001: load_data = {{(dataWidth-8){byte_sel[7]}}, byte_sel};
            3'b010: load_data = {{(dataWidth-8){1'b0}}, byte_sel};
            3'b011: load_data = {{(dataWidth-16){half_sel[15]}}, half_sel};
            3'b100: load_data = {{(dataWidth-16){1'b0}}, half_sel};
            default: load_data = ReadDataM;
        endcase
    end

    always_comb begin
        regwrite_d    = regwrite_q;
        writereg_d    = writereg_q;
        result_d      = result_q;
        valid_d       = valid_q;
        retired_cnt_d = retired_cnt_q;
        if (RST) begin
            regwrite_d    = 1'b0;
            writereg_d    = '0;
            result_d      = '0;
            valid_d       = 1'b0;
            retired_cnt_d = '0;
        end else if (FLUSH) begin
            regwrite_d = 1'b0;
            writereg_d = '0;
            result_d   = '0;
            valid_d    = 1'b0;
        end else if (!STALL) begin
            regwrite_d    = RegWriteM & ValidM & (WriteRegM != '0);
            writereg_d    = WriteRegM;
            result_d      = MemtoRegM ? load_data : ALUOutM;
            valid_d       = ValidM;
            retired_cnt_d = retired_cnt_q + {31'd0, ValidM};
        end
    end

    always_ff @(posedge CLK) begin
        regwrite_q    <= regwrite_d;
        writereg_q    <= writereg_d;
        result_q      <= result_d;
        valid_q       <= valid_d;
        retired_cnt_q <= retired_cnt_d;
    end

    assign RegWriteW    = regwrite_q;
    assign WriteRegW    = writereg_q;
    assign ResultW      = result_q;
    assign ValidW       = valid_q;
    assign RetiredCount = retired_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed spec vectors, then random
// traffic checked against an edge-by-edge reference model.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic        ValidM = 1'b0;
    logic        RegWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic [2:0]  LoadTypeM = 3'd0;
    logic [4:0]  WriteRegM = 5'd0;
    logic [31:0] ALUOutM = 32'd0;
    logic [31:0] ReadDataM = 32'd0;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        ValidW;
    logic [31:0] RetiredCount;

    mem_wb_stage #(.addWidth(5), .dataWidth(32)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .LoadTypeM(LoadTypeM), .WriteRegM(WriteRegM),
        .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .ValidW(ValidW), .RetiredCount(RetiredCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        regw;
        logic [4:0]  wreg;
        logic [31:0] res;
        logic        valid;
        logic [31:0] cnt;
        bit          chk;
        logic [31:0] gold;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic        m_regw = 0;
    logic [4:0]  m_wreg = 0;
    logic [31:0] m_res = 0;
    logic        m_valid = 0;
    logic [31:0] m_cnt = 0;

    function automatic logic [31:0] ref_load(input logic [2:0] lt,
                                             input logic [1:0] off,
                                             input logic [31:0] rd);
        longint unsigned b, h;
        b = (longint'(rd) >> (8 * int'(off))) % 256;
        h = (longint'(rd) >> (16 * (int'(off) / 2))) % 65536;
        case (lt)
            3'd1: return 32'(b >= 128 ? b + 64'hFFFFFF00 : b);
            3'd2: return 32'(b);
            3'd3: return 32'(h >= 32768 ? h + 64'hFFFF0000 : h);
            3'd4: return 32'(h);
            default: return rd;
        endcase
    endfunction

    task automatic model_edge(input bit rst, flush, stall, valid, regw, m2r,
                              input logic [2:0] lt, input logic [4:0] wr,
                              input logic [31:0] alu, rd);
        if (rst) begin
            m_regw = 0; m_wreg = 0; m_res = 0; m_valid = 0; m_cnt = 0;
        end else if (flush) begin
            m_regw = 0; m_wreg = 0; m_res = 0; m_valid = 0;
        end else if (!stall) begin
            m_regw  = regw && valid && (wr != 0);
            m_wreg  = wr;
            m_res   = m2r ? ref_load(lt, alu[1:0], rd) : alu;
            m_valid = valid;
            if (valid) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic push_exp(input bit chk, input logic [31:0] gold);
        exp_t e;
        e.regw = m_regw; e.wreg = m_wreg; e.res = m_res;
        e.valid = m_valid; e.cnt = m_cnt; e.chk = chk; e.gold = gold;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit rst, flush, stall, valid, regw, m2r,
                         input logic [2:0] lt, input logic [4:0] wr,
                         input logic [31:0] alu, rd);
        RST = rst; FLUSH = flush; STALL = stall; ValidM = valid;
        RegWriteM = regw; MemtoRegM = m2r; LoadTypeM = lt;
        WriteRegM = wr; ALUOutM = alu; ReadDataM = rd;
    endtask

    task automatic step(input bit rst, flush, stall, valid, regw, m2r,
                        input logic [2:0] lt, input logic [4:0] wr,
                        input logic [31:0] alu, rd,
                        input bit chk, input logic [31:0] gold);
        @(negedge CLK);
        drive(rst, flush, stall, valid, regw, m2r, lt, wr, alu, rd);
        model_edge(rst, flush, stall, valid, regw, m2r, lt, wr, alu, rd);
        push_exp(chk, gold);
    endtask

    task automatic load(input logic [2:0] lt, input logic [1:0] off,
                        input logic [31:0] gold);
        step(0, 0, 0, 1, 1, 1, lt, 5'd9, {30'h100, off}, 32'h80FF7F01,
             1, gold);
    endtask

    // Monitor: one expectation per edge, compared #1 after it
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if ({RegWriteW, WriteRegW, ResultW, ValidW, RetiredCount} !==
                    {e.regw, e.wreg, e.res, e.valid, e.cnt}) begin
                    miscompares++;
                    $display("FAIL outputs: got regw=%0b wreg=%0d res=%h valid=%0b cnt=%h, expected regw=%0b wreg=%0d res=%h valid=%0b cnt=%h",
                             RegWriteW, WriteRegW, ResultW, ValidW, RetiredCount,
                             e.regw, e.wreg, e.res, e.valid, e.cnt);
                end
                if (e.chk) begin
                    vectors++;
                    if (ResultW !== e.gold) begin
                        miscompares++;
                        $display("FAIL golden_result: got %h, expected %h",
                                 ResultW, e.gold);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d vectors", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        step(1, 0, 0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 1, 32'd0);
        // First ALU writeback
        step(0, 0, 0, 1, 1, 0, 3'd0, 5'd8, 32'h12345678, 32'hDEADBEEF,
             1, 32'h12345678);
        // Load alignment and extension
        load(3'd1, 2'd0, 32'h00000001);
        load(3'd1, 2'd1, 32'h0000007F);
        load(3'd1, 2'd2, 32'hFFFFFFFF);
        load(3'd1, 2'd3, 32'hFFFFFF80);
        load(3'd2, 2'd3, 32'h00000080);
        load(3'd3, 2'd2, 32'hFFFF80FF);
        load(3'd4, 2'd3, 32'h000080FF);
        load(3'd3, 2'd1, 32'h00007F01);
        load(3'd0, 2'd3, 32'h80FF7F01);
        load(3'd7, 2'd2, 32'h80FF7F01);
        // Write to x0 suppressed but still retired
        step(0, 0, 0, 1, 1, 0, 3'd0, 5'd0, 32'hAAAA5555, 32'd0, 0, 32'd0);
        // Stall three cycles with changing inputs, then stall+flush
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 1, 1, 0, 3'd0, 5'(i + 3), $urandom, $urandom, 0, 0);
        step(0, 1, 1, 1, 1, 0, 3'd0, 5'd4, 32'h55, 32'd0, 1, 32'd0);
        // Preload the counter near wrap, then two valid captures
        @(negedge CLK);
        force dut.retired_cnt_d = 32'hFFFFFFFE;
        drive(0, 0, 0, 0, 0, 0, 3'd0, 5'd1, 32'h1, 32'd0);
        model_edge(0, 0, 0, 0, 0, 0, 3'd0, 5'd1, 32'h1, 32'd0);
        m_cnt = 32'hFFFFFFFE;
        push_exp(0, 0);
        @(posedge CLK);
        #1;
        release dut.retired_cnt_d;
        step(0, 0, 0, 1, 1, 0, 3'd0, 5'd2, 32'h2, 32'd0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 3'd0, 5'd3, 32'h3, 32'd0, 0, 0);
        // Mid-stream reset with a valid instruction, then resume
        step(0, 0, 0, 1, 1, 0, 3'd0, 5'd5, 32'h77, 32'd0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 3'd1, 5'd6, 32'h99, 32'hFF, 1, 32'd0);
        step(0, 0, 0, 1, 1, 0, 3'd0, 5'd7, 32'hCAFE, 32'd0, 1, 32'hCAFE);
        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 3) != 0,
                 1'($urandom), 1'($urandom),
                 3'($urandom_range(0, 7)), 5'($urandom),
                 $urandom, $urandom, 0, 0);
        end
        @(negedge CLK);
        drive(0, 0, 1, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
